// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path types and defaults.
//   XLEN_DEFAULT / INSTR_W_DEFAULT : default PC and instruction widths
//   IFQ_DEPTH_DEFAULT              : default instruction fetch queue depth
//   fetch_entry_t                  : one queued fetch result {pc, instr}
package riscv_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int INSTR_W_DEFAULT   = 32;
  localparam int IFQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]    pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: generic synchronous circular FIFO.
//   clk, reset        : clock, synchronous active-high reset
//   flush_i           : empties the FIFO; wins over a same-cycle push/pop
//   push_i, data_i    : write port (push into a full FIFO is ignored unless a pop frees a slot)
//   pop_i, data_o     : read port; data_o always shows the head entry
//   count_o           : occupancy 0..DEPTH
//   full_o, empty_o   : status flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: pipelined, credit-limited instruction fetch front-end.
//   clk, reset              : clock, synchronous active-high reset
//   reset_adr_i             : PC loaded on reset
//   branch_v_i, branch_pc_i : redirect; flushes the queue, drops in-flight responses
//   imem_req_o, imem_adr_o  : fetch request / address, accepted on req && gnt
//   imem_gnt_i              : request grant
//   imem_rvalid_i/rdata_i   : in-order instruction response
//   instr_v_o, instr_o, pc_o: queue head toward decode
//   instr_rdy_i             : decode accepts head (pop on instr_v_o && instr_rdy_i)
//   count_o                 : queue occupancy
// Queued entries plus outstanding requests never exceed DEPTH, so the FIFO
// cannot overflow and never needs to back-pressure memory responses.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int DEPTH   = IFQ_DEPTH_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            reset_adr_i,
  input  logic                       branch_v_i,
  input  logic [XLEN-1:0]            branch_pc_i,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_adr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [INSTR_W-1:0]         imem_rdata_i,
  output logic                       instr_v_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [XLEN-1:0]            pc_o,
  input  logic                       instr_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int          CW      = $clog2(DEPTH+1);
  localparam int          EW      = XLEN + INSTR_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_pc;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d, occ;
  logic            credit_ok, gnt_fire, rv_ok, drop, push, pop;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   wdata, rdata;

  assign redirect_pc = {branch_pc_i[XLEN-1:2], 2'b00};

  assign credit_ok  = ({1'b0, occ} + {1'b0, inflight_q}) < DEPTH_C;
  assign imem_req_o = !reset && !branch_v_i && credit_ok;
  assign imem_adr_o = fetch_pc_q;
  assign gnt_fire   = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding is a protocol error; ignore it.
  assign rv_ok = imem_rvalid_i && (inflight_q != '0);
  assign drop  = rv_ok && (discard_q != '0);
  assign push  = rv_ok && !drop && !branch_v_i;

  assign instr_v_o = !fifo_empty;
  assign pop       = instr_v_o && instr_rdy_i && !branch_v_i;

  always_comb begin
    inflight_d = inflight_q + CW'(gnt_fire) - CW'(rv_ok);
    discard_d  = discard_q - CW'(drop);
    fetch_pc_d = gnt_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    resp_pc_d  = push     ? resp_pc_q  + XLEN'(4) : resp_pc_q;
    if (branch_v_i) begin
      // Everything still outstanding after this cycle's response is stale.
      discard_d  = inflight_d;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= reset_adr_i;
      resp_pc_q  <= reset_adr_i;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  assign wdata = {resp_pc_q, imem_rdata_i};

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (branch_v_i),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .data_o  (rdata),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {pc_o, instr_o} = rdata;
  assign count_o         = occ;

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid_i |-> (inflight_q != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] reset_adr_i = 32'h8000_0000;
  logic        branch_v_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_adr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_rdy_i = 1'b0;
  logic [2:0]  count_o;

  ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .INSTR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .reset_adr_i   (reset_adr_i),
    .branch_v_i    (branch_v_i),
    .branch_pc_i   (branch_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_adr_o    (imem_adr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_v_o     (instr_v_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_rdy_i   (instr_rdy_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // Memory-side view: every granted request in order, with its due cycle and
  // whether a redirect/reset has made it stale.
  typedef struct {
    int          due;
    logic [31:0] addr;
    bit          stale;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t fq[$];
  logic [31:0]  fetch_pc;
  logic [31:0]  deliver_pc;
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hc3a5, ~a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] adr);
    @(negedge clk);
    reset         = 1'b1;
    reset_adr_i   = adr;
    branch_v_i    = 1'b0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    instr_rdy_i   = 1'b1;
    #1;
    check("req_in_reset", 64'(imem_req_o), 64'(0));
    mq.delete();
    fq.delete();
    fetch_pc   = adr;
    deliver_pc = adr;
    cyc++;
  endtask

  // One clock: drive inputs at the falling edge, check outputs against the
  // model, then advance the model by what the coming rising edge does.
  task automatic cycle(input bit br, input logic [31:0] tgt, input bit g,
                       input bit r, input int lat);
    bit          rv, exp_req, exp_v;
    mreq_t       m;
    @(negedge clk);
    rv            = (mq.size() > 0) && (mq[0].due <= cyc);
    reset         = 1'b0;
    branch_v_i    = br;
    branch_pc_i   = tgt;
    imem_gnt_i    = g;
    instr_rdy_i   = r;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_data(mq[0].addr) : $urandom;
    #1;
    exp_req = !br && ((fq.size() + mq.size()) < DEPTH);
    exp_v   = fq.size() != 0;
    check("req", 64'(imem_req_o), 64'(exp_req));
    check("adr", 64'(imem_adr_o), 64'(fetch_pc));
    check("count", 64'(count_o), 64'(fq.size()));
    check("valid", 64'(instr_v_o), 64'(exp_v));
    if (exp_v) begin
      check("head_pc", 64'(pc_o), 64'(fq[0].pc));
      check("head_instr", 64'(instr_o), 64'(fq[0].instr));
    end
    if (exp_v && r && !br) begin
      check("pc_seq", 64'(pc_o), 64'(deliver_pc));
      deliver_pc = deliver_pc + 32'd4;
      void'(fq.pop_front());
    end
    if (rv) begin
      m = mq.pop_front();
      if (!br && !m.stale) fq.push_back('{pc: m.addr, instr: mem_data(m.addr)});
    end
    if (exp_req && g) begin
      mq.push_back('{due: cyc + lat, addr: fetch_pc, stale: 1'b0});
      fetch_pc = fetch_pc + 32'd4;
    end
    if (br) begin
      fq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      fetch_pc   = {tgt[31:2], 2'b00};
      deliver_pc = {tgt[31:2], 2'b00};
    end
    cyc++;
  endtask

  initial begin
    bit ok;

    // Streaming: one instruction per cycle with single-cycle memory.
    do_reset(32'h8000_0000);
    do_reset(32'h8000_0000);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1);

    // Backpressure until full, then drain.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1);

    // Flush with two responses outstanding and one entry queued.
    do_reset(32'h0000_4000);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle(1'b0, '0, (fq.size() + mq.size()) < 3, 1'b0, 3);
      ok = (fq.size() == 1) && (mq.size() == 2);
    end
    check("flush_setup_timeout", 64'(ok), 64'(1));
    cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0, 3);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b1, 3);

    // Redirect coincident with rvalid and pop, misaligned target.
    do_reset(32'h0000_1000);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1);
    cycle(1'b1, 32'h0000_0202, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1);

    // Pointer wrap with random decode stalls, plus PC wrap past 2^32.
    for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)), 1);
    cycle(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1, 1);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1);

    // Reset mid-operation with three queued and one outstanding.
    do_reset(32'h0000_2000);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1);
      ok = (fq.size() == 3) && (mq.size() == 1);
    end
    check("reset_setup_timeout", 64'(ok), 64'(1));
    do_reset(32'h0000_3000);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1);

    // Random traffic: grants, latencies, stalls and redirects.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(1, 4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
